// File: rtl/debug_uart_tx_if.sv
// rtl/debug_uart_tx_if.sv - capture inputs and UART/status outputs of the debug UART transmitter
interface debug_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    opcode;
    logic [7:0]    debug_dout;
    logic          tx;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output opcode, debug_dout,
        input  tx, tx_busy, fifo_count, overflow
    );

    modport slave (
        input  opcode, debug_dout,
        output tx, tx_busy, fifo_count, overflow
    );
endinterface

// File: rtl/debug_uart_tx.sv
// rtl/debug_uart_tx.sv - captures LD/ST debug bytes into a FIFO and sends them as UART 8N1 frames
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    debug_uart_tx_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic          cap_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bit_end;

    // Full/empty come from the pre-edge count, so a push while full is dropped even if a pop frees a slot.
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push    = cap_q && !full;
    assign pop     = (state_q == IDLE) && !empty;
    assign bit_end = (timer_q == BIT_END);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.debug_dout;
        end
    end

    // The debug register presents the byte one cycle after the LD/ST opcode, hence the delayed strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cap_q   <= (bus.opcode == 4'h5) || (bus.opcode == 4'h6);
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (cap_q && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // tx/busy are registered alongside the state so each line level starts on the same edge as its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        timer_q <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer_q   <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_busy    = busy_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb/tb_debug_uart_tx.sv - scoreboard bench decoding UART frames from debug_uart_tx
module tb_debug_uart_tx;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   frames = 0;
    int   last_start = -1;
    bit   mon_en = 1'b1;
    logic prev_tx = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] burst_d[16];

    debug_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic rx_frame();
        int st;
        logic [7:0] b;
        st = cyc;
        if (last_start >= 0) chk("frame_spacing", st - last_start, 10 * CPB + 1);
        last_start = st;
        repeat (CPB / 2) @(negedge clk);
        chk("start_bit", bus.tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", bus.tx, 1'b1);
        chk("busy_in_stop", bus.tx_busy, 1'b1);
        frames++;
        chk("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("rx_byte", b, exp_q.pop_front());
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && prev_tx && !bus.tx) rx_frame();
            prev_tx = bus.tx;
        end
    end

    // op for n cycles, then the n captured bytes follow one cycle behind
    task automatic send_burst(input logic [3:0] op, input int n);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            bus.opcode = (i < n) ? op : 4'h0;
            if (i > 0) bus.debug_dout = burst_d[i-1];
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.tx_busy || bus.fifo_count != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < 4000, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        int f0;
        bus.opcode = 4'h0;
        bus.debug_dout = 8'h00;

        // 1: reset held while LD/ST opcodes toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.opcode = (i % 2 == 0) ? 4'h5 : 4'h6;
            bus.debug_dout = 8'h40 + 8'(i);
        end
        @(negedge clk);
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_busy", bus.tx_busy, 1'b0);
        chk("rst_count", bus.fifo_count, 4'd0);
        chk("rst_overflow", bus.overflow, 1'b0);
        bus.opcode = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_count", bus.fifo_count, 4'd0);

        // 2: single ST with exact latency and busy length
        last_start = -1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        bus.opcode = 4'h6;
        @(negedge clk);
        bus.opcode = 4'h0;
        bus.debug_dout = 8'hA5;
        @(negedge clk);
        chk("st_count_after_push", bus.fifo_count, 4'd1);
        chk("st_busy_before_pop", bus.tx_busy, 1'b0);
        @(negedge clk);
        chk("st_busy_start", bus.tx_busy, 1'b1);
        chk("st_tx_start", bus.tx, 1'b0);
        chk("st_count_after_pop", bus.fifo_count, 4'd0);
        n = 0;
        while (bus.tx_busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("st_busy_cycles", n, 10 * CPB);
        drain();

        // 3: burst of three LD
        last_start = -1;
        f0 = frames;
        burst_d[0] = 8'h11; burst_d[1] = 8'h22; burst_d[2] = 8'h33;
        for (int i = 0; i < 3; i++) exp_q.push_back(burst_d[i]);
        send_burst(4'h5, 3);
        drain();
        chk("burst_frames", frames - f0, 3);
        chk("burst_count_zero", bus.fifo_count, 4'd0);

        // 4: overflow, ten ST back to back
        last_start = -1;
        f0 = frames;
        chk("pre_overflow", bus.overflow, 1'b0);
        for (int i = 0; i < 10; i++) burst_d[i] = 8'h80 + 8'(i * 7);
        for (int i = 0; i < 9; i++) exp_q.push_back(burst_d[i]);
        send_burst(4'h6, 10);
        @(negedge clk);
        chk("ovf_count_full", bus.fifo_count, 4'd8);
        chk("ovf_set", bus.overflow, 1'b1);
        drain();
        chk("ovf_frames", frames - f0, 9);
        chk("ovf_sticky", bus.overflow, 1'b1);

        // 5: non-capture opcodes
        f0 = frames;
        for (int op = 0; op < 16; op++) begin
            if (op == 5 || op == 6) continue;
            @(negedge clk);
            bus.opcode = 4'(op);
            bus.debug_dout = 8'($urandom);
            chk("nocap_count", bus.fifo_count, 4'd0);
            chk("nocap_tx", bus.tx, 1'b1);
        end
        @(negedge clk);
        bus.opcode = 4'h0;
        repeat (3) @(negedge clk);
        chk("nocap_count_end", bus.fifo_count, 4'd0);
        chk("nocap_frames", frames - f0, 0);

        // 6: reset during DATA bit 3, then a clean frame
        mon_en = 1'b0;
        burst_d[0] = 8'hA0;
        send_burst(4'h6, 1);
        n = 0;
        while (!bus.tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_busy_seen", bus.tx_busy, 1'b1);
        repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
        chk("mid_tx_low_bit3", bus.tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", bus.tx, 1'b1);
        chk("mid_rst_busy", bus.tx_busy, 1'b0);
        chk("mid_rst_count", bus.fifo_count, 4'd0);
        chk("mid_rst_overflow", bus.overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        last_start = -1;
        f0 = frames;
        burst_d[0] = 8'h5A;
        exp_q.push_back(8'h5A);
        send_burst(4'h6, 1);
        drain();
        chk("mid_clean_frames", frames - f0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
